dispatch_ctrl: RTL and testbench
================================

# dispatch_ctrl

Dual-slot dispatch controller between the two instruction decoders and the ID/EXE pipeline register. Each cycle it decides how many of the two oldest decoded instructions (0, 1 or 2) issue, and pops that count from the instruction buffer. It enforces the intra-pair RAW rule, the single memory-port rule and load-use interlock. Issued instructions are held in a registered output stage under the EXE ready/stall handshake.

## Interface
- `PAYLOAD_WIDTH`, 96: opaque per-slot bits carried to EXE (pc, imm, aluop, ...).
- `LOAD_USE_LAT`, 1: bubbles required between a load and a consumer of its rd (range 1-3).
- `GPR_NUM`, 32: architectural registers; the register address width is $clog2(GPR_NUM)=5.
- `clk` input 1: single clock; all state is updated on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `flush_i` input 1: pipeline flush (branch or exception).
- `slot_valid_i` input 2: buffer entries present; bit0 is the oldest; bit1 is only legal when bit0 is set.
- `decode_valid_i` input 2: per-slot decoder result valid.
- `reg_read_valid_i` input 2x2: per slot, {rk, rj} read enables.
- `reg_read_addr_i` input 2x10: per slot, {rk, rj}.
- `reg_write_valid_i` input 2: per-slot rd write enable.
- `reg_write_addr_i` input 2x5: per-slot rd.
- `alusel_i` input 2x3: per-slot result class; `EXE_RES_LOAD_STORE` marks a memory op.
- `is_load_i` input 2: the memory op in this slot is a load.
- `payload_i` input 2xPAYLOAD_WIDTH: pass-through bits.
- `consume_o` output 2: combinational pop mask; legal values are 00, 01 and 11.
- `exe_ready_i` input 1: EXE accepts the output register this cycle.
- `issue_valid_o` output 2: registered; slot valid toward EXE.
- `issue_info_o` output 2x(PAYLOAD_WIDTH+23): registered; per slot {payload, alusel, write valid/addr, read valid/addr}.

## Operation
- advance = exe_ready_i | ~|issue_valid_o. When advance=0, the output register holds and consume_o=00.
- blk0 is true when slot0 reads a register with a matching address for which a load-use lock is active (see below).
- Slot0 issues when advance & slot_valid_i[0] & ~blk0 & ~flush_i.
- A slot0 with decode_valid_i[0]=0 still issues, alone, with write and read valid forced to 0 and alusel=0. EXE raises INE from the payload.
- Slot1 issues only if slot0 issues, slot_valid_i[1]=1, decode_valid_i[1]=1, decode_valid_i[0]=1, and all of the following hold:
  - No RAW: slot0 has reg_write_valid_i=1 with rd≠0, and that rd matches one of slot1's valid read addresses.
  - Not two memory ops: both slots have alusel=LOAD_STORE.
  - No load-use block on slot1.
- consume_o = {slot1 issues, slot0 issues}.
- On advance, the output register loads the issuing slots. Slots that do not issue load valid=0, which is a bubble.
- Load-use lock: lu_rd (5 bits) and lu_cnt (2 bits).
  - It is armed when an issuing load has write valid and rd≠0: lu_rd=rd, lu_cnt=LOAD_USE_LAT.
  - lu_cnt decrements on each advance that does not re-arm it.
  - While lu_cnt≠0, a read of lu_rd is blocked.
  - A read of r0 is never blocked.
- Arbitration priority is oldest-first. Slot1 never issues without slot0.

## Timing
- Decision and consume_o are combinational in cycle t. The issued instruction is at issue_valid_o in cycle t+1.
- Reset (rst_n=0 at an edge) sets issue_valid_o=00, issue_info_o=0 and lu_cnt=0. consume_o is forced to 00 during reset.
- flush_i in cycle t has these effects:
  - consume_o=00 in t.
  - issue_valid_o=00 in t+1, regardless of exe_ready_i.
  - lu_cnt=0 in t+1.
- Flush has priority over a stall hold and over reset-free issue.
- Stall (exe_ready_i=0 with valid output) holds issue_info_o bit-exact. lu_cnt is frozen during a stall.
- With LOAD_USE_LAT=1, a load issued at t lets a dependent instruction issue at t+2 in the absence of stalls, giving exactly one bubble.
- Each `slot_valid_i`=10 cycle (a protocol violation) is treated as 00.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with slot_valid_i=11 → consume_o=00 throughout, and issue_valid_o=00 on the cycle after release.
- Independent pair: slot0 add r1←r2,r3 and slot1 or r4←r5,r6, exe_ready_i=1 → consume_o=11, then issue_valid_o=11 with matching rd 1/4.
- Intra-pair RAW and memory conflict, both with exe_ready_i=1:
  - RAW: slot0 writes r5 and slot1 reads r5 → consume_o=01. Next cycle the old slot1 sits at slot0 and issues (consume_o=01 or 11).
  - Two memory ops: slot0 ld.w and slot1 st.w → consume_o=01.
  - r0 is ignored for RAW: slot0 writes r0 and slot1 reads r0 → consume_o=11.
- Load-use: ld.w r7 issues at t, and the next instruction reads r7 → consume_o=00 at t+1, issue_valid_o=00 at t+2, consumer issues at t+2.
  - Repeat with exe_ready_i=0 for 3 cycles after the load → the bubble count is unchanged and the output is held.
- Stall: exe_ready_i=0 for 4 cycles with a valid pair captured → issue_info_o is constant and consume_o=00 for all 4 cycles.
- Flush with a load-use lock active and the output stalled: flush_i=1 for 1 cycle → issue_valid_o=00 next cycle, and the following read of lu_rd issues with no bubble.

Source files
------------

// File: rtl/dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// dispatch_ctrl
//   Dual-slot dispatch controller between the two decoders and the ID/EXE
//   pipeline register. Each cycle it chooses how many of the two oldest
//   decoded instructions issue (0, 1 or 2) and tells the instruction buffer
//   how many to pop. Slot1 is held back when it:
//     - reads slot0's rd (intra-pair RAW),
//     - would be a second memory op, or
//     - hits a load-use lock.
//   Issued slots are captured in a registered output stage that holds under
//   EXE back-pressure.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   flush_i             kill this cycle's issue and empty the output stage
//   slot_valid_i[1:0]   buffer entries present (bit0 = oldest)
//   decode_valid_i[1:0] decoder result valid per slot
//   reg_read_valid_i    per slot {rk, rj} read enables
//   reg_read_addr_i     per slot {rk, rj}
//   reg_write_valid_i   per slot rd write enable
//   reg_write_addr_i    per slot rd
//   alusel_i            per slot result class
//   is_load_i           per slot: memory op is a load
//   payload_i           per slot opaque bits carried to EXE
//   consume_o[1:0]      combinational pop mask (00, 01 or 11)
//   exe_ready_i         EXE accepts the output stage this cycle
//   issue_valid_o[1:0]  registered slot valids toward EXE
//   issue_info_o        registered per slot
//                       {payload, decode_valid, is_load, alusel,
//                        write valid, rd, read valids, {rk, rj}}
// -----------------------------------------------------------------------------
module dispatch_ctrl #(
  parameter int         PAYLOAD_WIDTH      = 96,
  parameter int         LOAD_USE_LAT       = 1,
  parameter int         GPR_NUM            = 32,
  parameter logic [2:0] EXE_RES_LOAD_STORE = 3'd4
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        flush_i,
  input  logic [1:0]                                  slot_valid_i,
  input  logic [1:0]                                  decode_valid_i,
  input  logic [1:0][1:0]                             reg_read_valid_i,
  input  logic [1:0][2*$clog2(GPR_NUM)-1:0]           reg_read_addr_i,
  input  logic [1:0]                                  reg_write_valid_i,
  input  logic [1:0][$clog2(GPR_NUM)-1:0]             reg_write_addr_i,
  input  logic [1:0][2:0]                             alusel_i,
  input  logic [1:0]                                  is_load_i,
  input  logic [1:0][PAYLOAD_WIDTH-1:0]               payload_i,
  output logic [1:0]                                  consume_o,
  input  logic                                        exe_ready_i,
  output logic [1:0]                                  issue_valid_o,
  output logic [1:0][PAYLOAD_WIDTH+22:0]              issue_info_o
);

  localparam int         AW     = $clog2(GPR_NUM);
  localparam int         IW     = PAYLOAD_WIDTH + 23;
  localparam logic [1:0] LU_LAT = 2'(LOAD_USE_LAT);

  // Load-use lock state
  logic [AW-1:0] lu_rd;
  logic [1:0]    lu_cnt;
  logic          lu_active;

  // Per-slot decoded views; an undecoded slot carries no reads/writes/class
  logic [1:0][1:0]    rd_en;
  logic [1:0]         wr_en;
  logic [1:0][2:0]    alu;
  logic [1:0]         is_mem;
  logic [1:0]         is_ld;
  logic [1:0]         lu_blk;
  logic [1:0][IW-1:0] info_next;

  assign lu_active = (lu_cnt != 2'd0);

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic [AW-1:0] rj;
    logic [AW-1:0] rk;
    assign rj = reg_read_addr_i[gi][AW-1:0];
    assign rk = reg_read_addr_i[gi][2*AW-1:AW];

    assign rd_en[gi]  = reg_read_valid_i[gi] & {2{decode_valid_i[gi]}};
    assign wr_en[gi]  = reg_write_valid_i[gi] & decode_valid_i[gi];
    assign alu[gi]    = decode_valid_i[gi] ? alusel_i[gi] : 3'd0;
    assign is_mem[gi] = (alu[gi] == EXE_RES_LOAD_STORE);
    assign is_ld[gi]  = is_mem[gi] & is_load_i[gi];

    // r0 is hard-wired zero, so a read of it never waits on a load
    assign lu_blk[gi] = lu_active &
                        ((rd_en[gi][0] & (rj != '0) & (rj == lu_rd)) |
                         (rd_en[gi][1] & (rk != '0) & (rk == lu_rd)));

    assign info_next[gi] = {payload_i[gi], decode_valid_i[gi], is_ld[gi], alu[gi],
                            wr_en[gi], reg_write_addr_i[gi], rd_en[gi],
                            reg_read_addr_i[gi]};
  end

  logic          advance;
  logic          raw_hazard;
  logic          mem_pair;
  logic          issue0;
  logic          issue1;
  logic          arm;
  logic [AW-1:0] arm_rd;

  always_comb begin
    advance    = exe_ready_i | ~|issue_valid_o;

    raw_hazard = wr_en[0] & (reg_write_addr_i[0] != '0) &
                 ((rd_en[1][0] & (reg_read_addr_i[1][AW-1:0]    == reg_write_addr_i[0])) |
                  (rd_en[1][1] & (reg_read_addr_i[1][2*AW-1:AW] == reg_write_addr_i[0])));
    mem_pair   = is_mem[0] & is_mem[1];

    // Slot_valid 10 is illegal; gating everything on bit0 treats it as 00
    issue0 = rst_n & advance & slot_valid_i[0] & ~lu_blk[0] & ~flush_i;
    issue1 = issue0 & slot_valid_i[1] & decode_valid_i[1] & decode_valid_i[0] &
             ~raw_hazard & ~mem_pair & ~lu_blk[1];

    // At most one load can issue per cycle, since two memory ops never pair
    arm    = 1'b0;
    arm_rd = reg_write_addr_i[0];
    if (issue1 && is_ld[1] && wr_en[1] && (reg_write_addr_i[1] != '0)) begin
      arm    = 1'b1;
      arm_rd = reg_write_addr_i[1];
    end else if (issue0 && is_ld[0] && wr_en[0] && (reg_write_addr_i[0] != '0)) begin
      arm    = 1'b1;
      arm_rd = reg_write_addr_i[0];
    end

    consume_o = {issue1, issue0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_valid_o <= '0;
      issue_info_o  <= '0;
      lu_cnt        <= '0;
      lu_rd         <= '0;
    end else if (flush_i) begin
      // Flushed instructions never reach EXE, so no lock survives either
      issue_valid_o <= '0;
      lu_cnt        <= '0;
    end else if (advance) begin
      issue_valid_o <= {issue1, issue0};
      for (int i = 0; i < 2; i++) begin
        if (consume_o[i]) begin
          issue_info_o[i] <= info_next[i];
        end
      end
      // The lock only counts down when the pipe actually moves
      if (arm) begin
        lu_rd  <= arm_rd;
        lu_cnt <= LU_LAT;
      end else if (lu_active) begin
        lu_cnt <= lu_cnt - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_ctrl.sv
module tb_dispatch_ctrl;

  localparam int         PW  = 96;
  localparam int         IW  = PW + 23;
  localparam logic [2:0] LS  = 3'd4;
  localparam logic [2:0] ALU = 3'd1;

  typedef struct packed {
    logic          dv;
    logic [2:0]    alu;
    logic          ld;
    logic          wv;
    logic [4:0]    wa;
    logic [1:0]    rv;
    logic [4:0]    rk;
    logic [4:0]    rj;
    logic [PW-1:0] pl;
  } instr_t;

  typedef struct {
    logic [1:0]    valid;
    logic [IW-1:0] info0;
    logic [IW-1:0] info1;
    logic          full;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       flush;
  logic       exe_ready;
  logic [1:0] slot_valid;
  instr_t     i0;
  instr_t     i1;

  logic [1:0]           decode_valid;
  logic [1:0][1:0]      reg_read_valid;
  logic [1:0][9:0]      reg_read_addr;
  logic [1:0]           reg_write_valid;
  logic [1:0][4:0]      reg_write_addr;
  logic [1:0][2:0]      alusel;
  logic [1:0]           is_load;
  logic [1:0][PW-1:0]   payload;
  logic [1:0]           consume;
  logic [1:0]           issue_valid;
  logic [1:0][IW-1:0]   issue_info;

  assign decode_valid      = {i1.dv, i0.dv};
  assign reg_read_valid[0] = i0.rv;
  assign reg_read_valid[1] = i1.rv;
  assign reg_read_addr[0]  = {i0.rk, i0.rj};
  assign reg_read_addr[1]  = {i1.rk, i1.rj};
  assign reg_write_valid   = {i1.wv, i0.wv};
  assign reg_write_addr[0] = i0.wa;
  assign reg_write_addr[1] = i1.wa;
  assign alusel[0]         = i0.alu;
  assign alusel[1]         = i1.alu;
  assign is_load           = {i1.ld, i0.ld};
  assign payload[0]        = i0.pl;
  assign payload[1]        = i1.pl;

  dispatch_ctrl #(
    .PAYLOAD_WIDTH      (PW),
    .LOAD_USE_LAT       (1),
    .GPR_NUM            (32),
    .EXE_RES_LOAD_STORE (LS)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush_i           (flush),
    .slot_valid_i      (slot_valid),
    .decode_valid_i    (decode_valid),
    .reg_read_valid_i  (reg_read_valid),
    .reg_read_addr_i   (reg_read_addr),
    .reg_write_valid_i (reg_write_valid),
    .reg_write_addr_i  (reg_write_addr),
    .alusel_i          (alusel),
    .is_load_i         (is_load),
    .payload_i         (payload),
    .consume_o         (consume),
    .exe_ready_i       (exe_ready),
    .issue_valid_o     (issue_valid),
    .issue_info_o      (issue_info)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic instr_t mk(input logic [2:0] alu, input logic ld, input logic wv,
                                input int wa, input logic [1:0] rv, input int rj,
                                input int rk, input int tag);
    instr_t r;
    r.dv  = 1'b1;
    r.alu = alu;
    r.ld  = ld;
    r.wv  = wv;
    r.wa  = 5'(wa);
    r.rv  = rv;
    r.rj  = 5'(rj);
    r.rk  = 5'(rk);
    r.pl  = {32'(tag), 32'hDEADBEEF, 32'(tag * 7 + 1)};
    return r;
  endfunction

  // What EXE should see for a slot that issued
  function automatic logic [IW-1:0] pack(input instr_t i);
    if (i.dv)
      return {i.pl, 1'b1, i.ld & (i.alu == LS), i.alu, i.wv, i.wa, i.rv, i.rk, i.rj};
    else
      return {i.pl, 1'b0, 1'b0, 3'd0, 1'b0, i.wa, 2'b00, i.rk, i.rj};
  endfunction

  // Model of the output stage, fed with the hand-derived pop mask
  logic [1:0]    m_valid = 2'b00;
  logic [IW-1:0] m_info0 = '0;
  logic [IW-1:0] m_info1 = '0;
  exp_t          sb[$];

  task automatic run_cycle(input logic [1:0] exp_cons, input string tag);
    exp_t e;
    @(negedge clk);
    check_eq({tag, "/consume"}, 128'(consume), 128'(exp_cons));
    e.full = 1'b0;
    if (!rst_n) begin
      m_valid = 2'b00;
      m_info0 = '0;
      m_info1 = '0;
      e.full  = 1'b1;
    end else if (flush) begin
      m_valid = 2'b00;
    end else if (exe_ready || (m_valid == 2'b00)) begin
      m_valid = exp_cons;
      if (exp_cons[0]) m_info0 = pack(i0);
      if (exp_cons[1]) m_info1 = pack(i1);
    end
    e.valid = m_valid;
    e.info0 = m_info0;
    e.info1 = m_info1;
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq({tag, "/issue_valid"}, 128'(issue_valid), 128'(e.valid));
    if (e.full || e.valid[0]) check_eq({tag, "/info0"}, 128'(issue_info[0]), 128'(e.info0));
    if (e.full || e.valid[1]) check_eq({tag, "/info1"}, 128'(issue_info[1]), 128'(e.info1));
    $display("cyc %-14s cons=%b valid=%b exp_cons=%b exp_valid=%b", tag, consume,
             issue_valid, exp_cons, e.valid);
  endtask

  task automatic set_in(input logic [1:0] sv, input logic rdy, input logic fl);
    slot_valid = sv;
    exe_ready  = rdy;
    flush      = fl;
  endtask

  instr_t ld_r7, use_r7, ld_r9, use_r9, add_a, or_b;

  initial begin
    add_a  = mk(ALU, 0, 1, 1, 2'b11, 2, 3, 1);
    or_b   = mk(ALU, 0, 1, 4, 2'b11, 5, 6, 2);
    ld_r7  = mk(LS, 1, 1, 7, 2'b01, 2, 0, 10);
    use_r7 = mk(ALU, 0, 1, 8, 2'b10, 0, 7, 11);
    ld_r9  = mk(LS, 1, 1, 9, 2'b01, 3, 0, 20);
    use_r9 = mk(ALU, 0, 1, 10, 2'b01, 9, 0, 21);

    // Reset held two cycles with a full pair presented
    rst_n = 1'b0;
    i0 = add_a; i1 = or_b;
    set_in(2'b11, 1'b1, 1'b0);
    run_cycle(2'b00, "reset0");
    run_cycle(2'b00, "reset1");
    rst_n = 1'b1;
    set_in(2'b00, 1'b1, 1'b0);
    run_cycle(2'b00, "post_reset");

    // Independent pair
    set_in(2'b11, 1'b1, 1'b0);
    run_cycle(2'b11, "indep_pair");

    // Intra-pair RAW on r5, then the held-back slot1 moves to slot0
    i0 = mk(ALU, 0, 1, 5, 2'b11, 1, 2, 30);
    i1 = mk(ALU, 0, 1, 8, 2'b11, 5, 3, 31);
    run_cycle(2'b01, "raw");
    i0 = i1;
    i1 = mk(ALU, 0, 1, 9, 2'b11, 10, 11, 32);
    run_cycle(2'b11, "raw_next");

    // Two memory ops: ld.w r12 then st.w
    i0 = mk(LS, 1, 1, 12, 2'b01, 13, 0, 40);
    i1 = mk(LS, 0, 0, 0, 2'b11, 14, 15, 41);
    run_cycle(2'b01, "mem_pair");
    i0 = i1;
    set_in(2'b01, 1'b1, 1'b0);
    run_cycle(2'b01, "mem_store");

    // r0 never forms a RAW dependency
    i0 = mk(ALU, 0, 1, 0, 2'b11, 1, 2, 50);
    i1 = mk(ALU, 0, 1, 6, 2'b11, 0, 0, 51);
    set_in(2'b11, 1'b1, 1'b0);
    run_cycle(2'b11, "r0_pair");

    // Load-use: exactly one bubble
    i0 = ld_r7;
    set_in(2'b01, 1'b1, 1'b0);
    run_cycle(2'b01, "lu_load");
    i0 = use_r7;
    run_cycle(2'b00, "lu_block");
    run_cycle(2'b01, "lu_consumer");
    set_in(2'b00, 1'b1, 1'b0);
    run_cycle(2'b00, "lu_drain");

    // Load-use with a 3-cycle stall behind the load
    i0 = ld_r7;
    set_in(2'b01, 1'b1, 1'b0);
    run_cycle(2'b01, "lus_load");
    i0 = use_r7;
    set_in(2'b01, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) run_cycle(2'b00, "lus_stall");
    set_in(2'b01, 1'b1, 1'b0);
    run_cycle(2'b00, "lus_bubble");
    run_cycle(2'b01, "lus_consumer");

    // Load-use block on slot1 only
    i0 = ld_r7;
    run_cycle(2'b01, "lu1_load");
    i0 = add_a; i1 = use_r7;
    set_in(2'b11, 1'b1, 1'b0);
    run_cycle(2'b01, "lu1_block");
    i0 = use_r7; i1 = or_b;
    run_cycle(2'b11, "lu1_release");

    // Stall four cycles with a captured pair; output held bit-exact
    i0 = add_a; i1 = or_b;
    run_cycle(2'b11, "stall_cap");
    i0 = mk(ALU, 0, 1, 20, 2'b11, 21, 22, 60);
    i1 = mk(ALU, 0, 1, 23, 2'b11, 24, 25, 61);
    set_in(2'b11, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) run_cycle(2'b00, "stall_hold");
    set_in(2'b11, 1'b1, 1'b0);
    run_cycle(2'b11, "stall_release");

    // Flush with a lock active and the output stalled
    i0 = ld_r9;
    set_in(2'b01, 1'b1, 1'b0);
    run_cycle(2'b01, "fl_load");
    i0 = use_r9;
    set_in(2'b01, 1'b0, 1'b0);
    run_cycle(2'b00, "fl_stall");
    set_in(2'b01, 1'b0, 1'b1);
    run_cycle(2'b00, "fl_flush");
    set_in(2'b01, 1'b0, 1'b0);
    run_cycle(2'b01, "fl_no_bubble");
    set_in(2'b00, 1'b1, 1'b0);
    run_cycle(2'b00, "fl_drain");

    // Flush with EXE ready and a pair present
    i0 = add_a; i1 = or_b;
    set_in(2'b11, 1'b1, 1'b1);
    run_cycle(2'b00, "flush_pair");

    // Undecoded slot0 issues alone with fields masked and arms no lock
    i0 = mk(LS, 1, 1, 3, 2'b11, 4, 5, 70);
    i0.dv = 1'b0;
    i1 = or_b;
    set_in(2'b11, 1'b1, 1'b0);
    run_cycle(2'b01, "ine_slot0");
    i0 = mk(ALU, 0, 1, 11, 2'b01, 3, 0, 71);
    set_in(2'b01, 1'b1, 1'b0);
    run_cycle(2'b01, "ine_no_lock");

    // Illegal slot_valid 10 behaves as empty
    i0 = add_a; i1 = or_b;
    set_in(2'b10, 1'b1, 1'b0);
    run_cycle(2'b00, "sv_10");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
